mod12_seq_checker: RTL and testbench



---
 rtl/mod12_pkg.sv | 14 +
 rtl/mod12_seq_checker_if.sv | 29 ++
 rtl/mod_n_inc.sv | 21 ++
 rtl/mod12_seq_checker.sv | 151 +++++++++++++++
 tb/tb_mod12_seq_checker.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mod12_pkg.sv
// Shared constants and state encoding for the mod-12 counter family and its
// receive-side sequence checker.
package mod12_pkg;

    localparam int MOD12 = 12;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

endpackage

// File: rtl/mod12_seq_checker_if.sv
// Count-stream bus between the counter side (master) and the sequence checker (slave).
interface mod12_seq_checker_if
    import mod12_pkg::*;
#(
    parameter int W      = CNT_W,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
);

    logic [W-1:0]      cnt_in;
    logic              cnt_vld;
    logic              clr_stats;
    logic              locked;
    logic              err_pulse;
    logic              wrap_pulse;
    logic [ERR_W-1:0]  err_cnt;
    logic [WRAP_W-1:0] wrap_cnt;

    modport master (
        output cnt_in, cnt_vld, clr_stats,
        input  locked, err_pulse, wrap_pulse, err_cnt, wrap_cnt
    );

    modport slave (
        input  cnt_in, cnt_vld, clr_stats,
        output locked, err_pulse, wrap_pulse, err_cnt, wrap_cnt
    );

endinterface

// File: rtl/mod_n_inc.sv
// Combinational modulo-MOD successor: y = (x == MOD-1) ? 0 : x + 1.
module mod_n_inc #(
    parameter int MOD = 12,
    parameter int W   = 4
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // successor with wrap at the last legal code
    always_comb begin
        if (x == LAST) begin
            y = {W{1'b0}};
        end else begin
            y = x + W'(1);
        end
    end

endmodule

// File: rtl/mod12_seq_checker.sv
// Receive-side checker for the mod-12 count stream: locks onto 0..MOD-1, counts wraps,
// flags skips, repeats and illegal codes, and keeps saturating error statistics.
module mod12_seq_checker
    import mod12_pkg::*;
#(
    parameter int MOD    = MOD12,
    parameter int W      = CNT_W,
    parameter int LOCK_N = 2,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mod12_seq_checker_if.slave   bus
);

    localparam logic [W:0]   MOD_V  = (W + 1)'(MOD);
    localparam logic [2:0]   LOCK_V = 3'(LOCK_N);
    localparam state_t       FIRST_ST = (LOCK_N == 1) ? LOCK : SYNC;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
    endfunction

    state_t            state_r, state_nxt_s;
    logic [W-1:0]      exp_r, exp_nxt_s;
    logic [2:0]        match_r, match_nxt_s;
    logic [2:0]        match_inc_s;
    logic [W-1:0]      nxt_in_s;
    logic              illegal_s;
    logic              hit_s;
    logic              err_s;
    logic              wrap_s;

    logic              locked_r;
    logic              err_pulse_r;
    logic              wrap_pulse_r;
    logic [ERR_W-1:0]  err_cnt_r;
    logic [WRAP_W-1:0] wrap_cnt_r;

    mod_n_inc #(.MOD(MOD), .W(W)) u_inc (
        .x (bus.cnt_in),
        .y (nxt_in_s)
    );

    assign illegal_s   = ({1'b0, bus.cnt_in} >= MOD_V);
    assign hit_s       = (bus.cnt_in == exp_r);
    assign match_inc_s = match_r + 3'd1;

    // next-state, expected value, match count and pulse decode
    always_comb begin
        state_nxt_s = state_r;
        exp_nxt_s   = exp_r;
        match_nxt_s = match_r;
        err_s       = 1'b0;
        wrap_s      = 1'b0;
        if (bus.cnt_vld) begin
            case (state_r)
                HUNT: begin
                    if (illegal_s) begin
                        err_s = 1'b1;
                    end else begin
                        exp_nxt_s   = nxt_in_s;
                        match_nxt_s = 3'd1;
                        state_nxt_s = FIRST_ST;
                    end
                end
                SYNC: begin
                    if (illegal_s) begin
                        err_s       = 1'b1;
                        match_nxt_s = 3'd0;
                        state_nxt_s = HUNT;
                    end else if (hit_s) begin
                        exp_nxt_s   = nxt_in_s;
                        match_nxt_s = match_inc_s;
                        if (match_inc_s >= LOCK_V) begin
                            state_nxt_s = LOCK;
                        end else begin
                            state_nxt_s = SYNC;
                        end
                    end else begin
                        // a legal mismatch while syncing is just a new seed, not an error
                        exp_nxt_s   = nxt_in_s;
                        match_nxt_s = 3'd1;
                    end
                end
                LOCK: begin
                    if (illegal_s) begin
                        err_s       = 1'b1;
                        match_nxt_s = 3'd0;
                        state_nxt_s = HUNT;
                    end else if (hit_s) begin
                        exp_nxt_s = nxt_in_s;
                        wrap_s    = (bus.cnt_in == {W{1'b0}});
                    end else begin
                        err_s       = 1'b1;
                        exp_nxt_s   = nxt_in_s;
                        match_nxt_s = 3'd1;
                        state_nxt_s = SYNC;
                    end
                end
                default: begin
                    match_nxt_s = 3'd0;
                    state_nxt_s = HUNT;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM, tracking registers, registered outputs and statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= HUNT;
            exp_r        <= {W{1'b0}};
            match_r      <= 3'd0;
            locked_r     <= 1'b0;
            err_pulse_r  <= 1'b0;
            wrap_pulse_r <= 1'b0;
            err_cnt_r    <= {ERR_W{1'b0}};
            wrap_cnt_r   <= {WRAP_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            exp_r        <= exp_nxt_s;
            match_r      <= match_nxt_s;
            locked_r     <= (state_nxt_s == LOCK);
            err_pulse_r  <= err_s;
            wrap_pulse_r <= wrap_s;
            // clear takes priority over an increment on the same edge
            if (bus.clr_stats) begin
                err_cnt_r  <= {ERR_W{1'b0}};
                wrap_cnt_r <= {WRAP_W{1'b0}};
            end else begin
                if (err_s) begin
                    err_cnt_r <= sat_inc(err_cnt_r);
                end
                if (wrap_s) begin
                    wrap_cnt_r <= wrap_cnt_r + WRAP_W'(1);
                end
            end
        end
    end

    assign bus.locked     = locked_r;
    assign bus.err_pulse  = err_pulse_r;
    assign bus.wrap_pulse = wrap_pulse_r;
    assign bus.err_cnt    = err_cnt_r;
    assign bus.wrap_cnt   = wrap_cnt_r;

endmodule

// File: tb/tb_mod12_seq_checker.sv
// Self-checking bench for mod12_seq_checker: scenario tasks plus a scoreboard of
// expected per-sample responses produced by a small behavioural model.
module tb_mod12_seq_checker;

    logic clk;
    logic reset;

    mod12_seq_checker_if #(.W(4), .ERR_W(8), .WRAP_W(8)) bus ();

    mod12_seq_checker #(
        .MOD(12), .W(4), .LOCK_N(2), .ERR_W(8), .WRAP_W(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct packed {
        logic       locked;
        logic       err;
        logic       wrap;
        logic [7:0] errc;
        logic [7:0] wrapc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    int m_state, m_exp, m_match, m_err, m_wrap;

    task automatic model_reset();
        m_state = 0; m_exp = 0; m_match = 0; m_err = 0; m_wrap = 0;
        sb.delete();
    endtask

    task automatic model_step(input int v, input bit vld, input bit clr);
        bit   e, w;
        exp_t x;
        e = 1'b0; w = 1'b0;
        if (vld) begin
            if (m_state == 0) begin
                if (v >= 12) e = 1'b1;
                else begin m_exp = (v + 1) % 12; m_match = 1; m_state = 1; end
            end else if (m_state == 1) begin
                if (v >= 12) begin e = 1'b1; m_state = 0; end
                else if (v == m_exp) begin
                    m_exp = (v + 1) % 12; m_match++;
                    if (m_match >= 2) m_state = 2;
                end else begin m_exp = (v + 1) % 12; m_match = 1; end
            end else begin
                if (v >= 12) begin e = 1'b1; m_state = 0; end
                else if (v == m_exp) begin m_exp = (v + 1) % 12; w = (v == 0); end
                else begin e = 1'b1; m_exp = (v + 1) % 12; m_match = 1; m_state = 1; end
            end
        end
        if (clr) begin m_err = 0; m_wrap = 0; end
        else begin
            if (e && m_err < 255) m_err++;
            if (w) m_wrap = (m_wrap + 1) % 256;
        end
        x.locked = (m_state == 2); x.err = e; x.wrap = w;
        x.errc = 8'(m_err); x.wrapc = 8'(m_wrap);
        sb.push_back(x);
    endtask

    // drive one sample, push its expected response, then compare one clock later
    task automatic drive(input int v, input bit vld, input bit clr);
        exp_t e, got;
        @(negedge clk);
        bus.cnt_in = 4'(v); bus.cnt_vld = vld; bus.clr_stats = clr;
        model_step(v, vld, clr);
        @(posedge clk);
        #1;
        got = {bus.locked, bus.err_pulse, bus.wrap_pulse, bus.err_cnt, bus.wrap_cnt};
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL scoreboard cnt=%0d vld=%0b clr=%0b got lk=%0b ep=%0b wp=%0b ec=%0d wc=%0d want lk=%0b ep=%0b wp=%0b ec=%0d wc=%0d",
                     v, vld, clr, got.locked, got.err, got.wrap, got.errc, got.wrapc,
                     e.locked, e.err, e.wrap, e.errc, e.wrapc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.cnt_in = 4'd0; bus.cnt_vld = 1'b0; bus.clr_stats = 1'b0;
        model_reset();
        #15;
        total++;
        if ({bus.locked, bus.err_pulse, bus.wrap_pulse, bus.err_cnt, bus.wrap_cnt} !== 19'd0) begin
            bad++;
            $display("FAIL reset_state got lk=%0b ep=%0b wp=%0b ec=%0d wc=%0d want all 0",
                     bus.locked, bus.err_pulse, bus.wrap_pulse, bus.err_cnt, bus.wrap_cnt);
        end
        #5 reset = 1'b1;
    endtask

    task automatic test_count_stream();
        for (int i = 0; i < 37; i++) begin
            drive(i % 12, 1'b1, 1'b0);
            if (i == 0) begin
                total++;
                if (bus.locked !== 1'b0) begin bad++; $display("FAIL lock_after_1st got %0b want 0", bus.locked); end
            end
            if (i == 1) begin
                total++;
                if (bus.locked !== 1'b1) begin bad++; $display("FAIL lock_after_2nd got %0b want 1", bus.locked); end
            end
        end
        total++;
        if (bus.wrap_cnt !== 8'd3 || bus.err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL three_cycles got wc=%0d ec=%0d want wc=3 ec=0", bus.wrap_cnt, bus.err_cnt);
        end
    endtask

    task automatic test_skip();
        int seq[8] = '{1, 2, 3, 4, 5, 7, 8, 9};
        foreach (seq[i]) begin
            drive(seq[i], 1'b1, 1'b0);
            if (seq[i] == 7) begin
                total++;
                if (bus.err_pulse !== 1'b1 || bus.err_cnt !== 8'd1 || bus.locked !== 1'b0) begin
                    bad++;
                    $display("FAIL skip_detect got ep=%0b ec=%0d lk=%0b want ep=1 ec=1 lk=0",
                             bus.err_pulse, bus.err_cnt, bus.locked);
                end
            end
            if (seq[i] == 8) begin
                total++;
                if (bus.locked !== 1'b1) begin bad++; $display("FAIL relock_after_skip got %0b want 1", bus.locked); end
            end
        end
    endtask

    task automatic test_illegal();
        drive(13, 1'b1, 1'b0);
        total++;
        if (bus.err_pulse !== 1'b1 || bus.err_cnt !== 8'd2 || bus.locked !== 1'b0) begin
            bad++;
            $display("FAIL illegal_code got ep=%0b ec=%0d lk=%0b want ep=1 ec=2 lk=0",
                     bus.err_pulse, bus.err_cnt, bus.locked);
        end
        drive(3, 1'b1, 1'b0);
        drive(4, 1'b1, 1'b0);
        total++;
        if (bus.locked !== 1'b1) begin bad++; $display("FAIL relock_after_illegal got %0b want 1", bus.locked); end
    endtask

    task automatic test_vld_hold();
        for (int i = 0; i < 5; i++) drive(9, 1'b0, 1'b0);
        total++;
        if (bus.locked !== 1'b1 || bus.err_pulse !== 1'b0) begin
            bad++;
            $display("FAIL vld_hold got lk=%0b ep=%0b want lk=1 ep=0", bus.locked, bus.err_pulse);
        end
        drive(5, 1'b1, 1'b0);
        total++;
        if (bus.locked !== 1'b1 || bus.err_pulse !== 1'b0) begin
            bad++;
            $display("FAIL resume_expected got lk=%0b ep=%0b want lk=1 ep=0", bus.locked, bus.err_pulse);
        end
    endtask

    task automatic test_async_reset();
        drive(7, 1'b1, 1'b0);
        drive(8, 1'b1, 1'b0);
        total++;
        if (bus.locked !== 1'b1 || bus.err_cnt !== 8'd3 || bus.wrap_cnt !== 8'd3) begin
            bad++;
            $display("FAIL pre_reset got lk=%0b ec=%0d wc=%0d want lk=1 ec=3 wc=3",
                     bus.locked, bus.err_cnt, bus.wrap_cnt);
        end
        @(posedge clk);
        #5 reset = 1'b0;
        #2;
        total++;
        if (bus.locked !== 1'b0 || bus.err_cnt !== 8'd0 || bus.wrap_cnt !== 8'd0) begin
            bad++;
            $display("FAIL async_reset got lk=%0b ec=%0d wc=%0d want 0 0 0",
                     bus.locked, bus.err_cnt, bus.wrap_cnt);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b1, 1'b0);
        drive(1, 1'b1, 1'b0);
        total++;
        if (bus.locked !== 1'b1) begin bad++; $display("FAIL relock_after_reset got %0b want 1", bus.locked); end
    endtask

    task automatic test_saturate_and_clear();
        for (int i = 0; i < 260; i++) drive(13, 1'b1, 1'b0);
        total++;
        if (bus.err_cnt !== 8'd255) begin bad++; $display("FAIL err_saturate got %0d want 255", bus.err_cnt); end
        drive(14, 1'b1, 1'b1);
        total++;
        if (bus.err_cnt !== 8'd0 || bus.err_pulse !== 1'b1) begin
            bad++;
            $display("FAIL clear_wins got ec=%0d ep=%0b want ec=0 ep=1", bus.err_cnt, bus.err_pulse);
        end
    endtask

    task automatic test_wrap_rollover();
        for (int i = 0; i < 256 * 12 + 1; i++) drive(i % 12, 1'b1, 1'b0);
        total++;
        if (bus.wrap_cnt !== 8'd0 || bus.wrap_pulse !== 1'b1) begin
            bad++;
            $display("FAIL wrap_rollover got wc=%0d wp=%0b want wc=0 wp=1", bus.wrap_cnt, bus.wrap_pulse);
        end
    endtask

    initial begin
        test_reset();
        test_count_stream();
        test_skip();
        test_illegal();
        test_vld_hold();
        test_async_reset();
        test_saturate_and_clear();
        test_wrap_rollover();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
